// File: rtl/mem_responder_if.sv
// Cache-to-main-memory request/response bundle: request, write-data and read-response channels.
// master = cache side, slave = memory side.
interface mem_responder_if #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28
);
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [MEM_ADDR_BITS-1:0]     mem_req_addr;
    logic                         mem_req_rw;
    logic                         mem_req_data_valid;
    logic                         mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0]     mem_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0]   mem_req_data_mask;
    logic                         mem_resp_valid;
    logic [MEM_DATA_BITS-1:0]     mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_responder.sv
// Main-memory stand-in: single-beat masked writes, 4-beat wrapping line reads returned
// after a fixed latency with no backpressure.
module mem_responder #(
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28,
    parameter int DEPTH_LOG2    = 12,
    parameter int READ_LATENCY  = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_responder_if.slave   bus
);
    localparam int         MASK_BITS = MEM_DATA_BITS / 8;
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_INIT  = 8'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, W_DATA, R_WAIT, R_BURST} state_t;

    state_t                    state_q, state_d;
    logic [DEPTH_LOG2-1:0]     addr_q, addr_d;
    logic [7:0]                lat_cnt_q, lat_cnt_d;
    logic [2:0]                beat_q, beat_d;
    logic                      ready_q, ready_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [MEM_DATA_BITS-1:0]  resp_data_q, resp_data_d;

    logic [MEM_DATA_BITS-1:0]  mem [DEPTH];

    logic                      accept;
    logic                      data_ready;
    logic                      wr_en;
    logic [DEPTH_LOG2-1:0]     wr_idx;
    logic [DEPTH_LOG2-1:0]     rd_idx;
    logic [1:0]                rd_off;
    logic                      unused_addr_hi;

    // ready_q is only ever high in IDLE, so it also gates acceptance right after reset release
    assign accept         = ready_q && bus.mem_req_valid;
    assign data_ready     = (accept && bus.mem_req_rw) || (state_q == W_DATA);
    assign wr_en          = data_ready && bus.mem_req_data_valid;
    assign wr_idx         = (state_q == W_DATA) ? addr_q : bus.mem_req_addr[DEPTH_LOG2-1:0];
    assign rd_off         = addr_q[1:0] + beat_q[1:0];
    assign rd_idx         = {addr_q[DEPTH_LOG2-1:2], rd_off};
    assign unused_addr_hi = ^bus.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2];

    assign bus.mem_req_ready      = ready_q;
    assign bus.mem_req_data_ready = data_ready;
    assign bus.mem_resp_valid     = resp_valid_q;
    assign bus.mem_resp_data      = resp_data_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lat_cnt_d    = lat_cnt_q;
        beat_d       = beat_q;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = bus.mem_req_addr[DEPTH_LOG2-1:0];
                    if (bus.mem_req_rw) begin
                        if (!bus.mem_req_data_valid) state_d = W_DATA;
                    end else begin
                        lat_cnt_d = LAT_INIT;
                        beat_d    = '0;
                        state_d   = (READ_LATENCY == 1) ? R_BURST : R_WAIT;
                    end
                end
            end
            W_DATA: begin
                if (bus.mem_req_data_valid) state_d = IDLE;
            end
            R_WAIT: begin
                // leave as the counter reaches zero so beat 0 lands READ_LATENCY edges after accept
                lat_cnt_d = lat_cnt_q - 8'd1;
                if (lat_cnt_q == 8'd1) state_d = R_BURST;
            end
            R_BURST: begin
                // beat_q==4 is a drain cycle so ready rises the cycle after the last beat
                if (beat_q[2]) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem[rd_idx];
                    beat_d       = beat_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            lat_cnt_q    <= '0;
            beat_q       <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lat_cnt_q    <= lat_cnt_d;
            beat_q       <= beat_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < MASK_BITS; b++) begin
                if (bus.mem_req_data_mask[b]) mem[wr_idx][b*8 +: 8] <= bus.mem_req_data_bits[b*8 +: 8];
            end
        end
    end
endmodule
